activity_led_array: RTL and testbench

//  Multi-channel activity indicator for FPGA top-levels. Generalises the single-channel activity LED:
//  N channels, per-channel synchroniser, selectable trigger mode, retriggerable pulse stretch,
//  per-channel force and a shared PWM brightness control. Sits beside the reset generator and

---
 rtl/activity_led_array.sv | 98 +++++++++
 tb/tb_activity_led_array.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/activity_led_array.sv
// Multi-channel activity LED driver: each channel synchronises an async input, detects
// activity, stretches it to a visible pulse, and drives a registered LED gated by a shared PWM.
module activity_led_lane #(
  parameter int   WIDTH        = 256,
  parameter int   SYNC_STAGES  = 2,
  parameter int   TRIG_MODE    = 0,
  parameter logic ACTIVE_LEVEL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  input  logic force_on,
  input  logic pwm_on,
  output logic o
);
  localparam int CW = $clog2(WIDTH + 1);

  logic [SYNC_STAGES-1:0] s;
  logic                   si;
  logic                   prev;
  logic                   trg;
  logic [CW-1:0]          ctr;

  assign si = s[SYNC_STAGES-1];

  always_comb begin
    trg = si;
    if (TRIG_MODE == 0)      trg = si ^ prev;
    else if (TRIG_MODE == 1) trg = si & ~prev;
  end

  // o uses the pre-edge ctr, so a fresh trigger shows one cycle after the reload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s    <= '0;
      prev <= 1'b0;
      ctr  <= '0;
      o    <= ~ACTIVE_LEVEL;
    end else begin
      s    <= {s[SYNC_STAGES-2:0], i};
      prev <= si;
      if (trg)              ctr <= CW'(WIDTH);
      else if (ctr != '0)   ctr <= ctr - CW'(1);
      o    <= (((ctr != '0) | force_on) & pwm_on) ? ACTIVE_LEVEL : ~ACTIVE_LEVEL;
    end
  end
endmodule

module activity_led_array #(
  parameter int   N_CHANNELS   = 4,
  parameter int   WIDTH        = 256,
  parameter int   SYNC_STAGES  = 2,
  parameter int   TRIG_MODE    = 0,
  parameter logic ACTIVE_LEVEL = 1'b0,
  parameter int   PWM_BITS     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CHANNELS-1:0] i,
  input  logic [N_CHANNELS-1:0] force_on,
  input  logic [PWM_BITS:0]     brightness,
  output logic [N_CHANNELS-1:0] o
);
  logic pwm_on;

  // brightness has one extra bit so 2**PWM_BITS (and above) means fully on
  generate
    if (PWM_BITS > 0) begin : g_pwm
      logic [PWM_BITS-1:0] pwm_ctr;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) pwm_ctr <= '0;
        else     pwm_ctr <= pwm_ctr + PWM_BITS'(1);
      end
      assign pwm_on = ({1'b0, pwm_ctr} < brightness);
    end else begin : g_nopwm
      assign pwm_on = brightness[0];
    end
  endgenerate

  genvar c;
  generate
    for (c = 0; c < N_CHANNELS; c++) begin : g_lane
      activity_led_lane #(
        .WIDTH        (WIDTH),
        .SYNC_STAGES  (SYNC_STAGES),
        .TRIG_MODE    (TRIG_MODE),
        .ACTIVE_LEVEL (ACTIVE_LEVEL)
      ) u_lane (
        .clk      (clk),
        .rst      (rst),
        .i        (i[c]),
        .force_on (force_on[c]),
        .pwm_on   (pwm_on),
        .o        (o[c])
      );
    end
  endgenerate
endmodule

// File: tb/tb_activity_led_array.sv
// Scoreboard bench for activity_led_array: three instances cover any-edge, rising-edge and
// level trigger modes, without PWM and with a 4-bit PWM.
module tb_activity_led_array;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] i0, f0, o0, i1, f1, o1, i2, f2, o2;
  logic       b0, b1;
  logic [4:0] b2;

  logic [31:0] exp_q[$];
  int tests_run = 0;
  int fails     = 0;

  always #5 clk = ~clk;

  activity_led_array #(.N_CHANNELS(4), .WIDTH(8), .SYNC_STAGES(2), .TRIG_MODE(0),
                       .ACTIVE_LEVEL(1'b0), .PWM_BITS(0))
    dut0 (.clk(clk), .rst(rst), .i(i0), .force_on(f0), .brightness(b0), .o(o0));
  activity_led_array #(.N_CHANNELS(4), .WIDTH(8), .SYNC_STAGES(2), .TRIG_MODE(1),
                       .ACTIVE_LEVEL(1'b0), .PWM_BITS(0))
    dut1 (.clk(clk), .rst(rst), .i(i1), .force_on(f1), .brightness(b1), .o(o1));
  activity_led_array #(.N_CHANNELS(4), .WIDTH(8), .SYNC_STAGES(2), .TRIG_MODE(2),
                       .ACTIVE_LEVEL(1'b0), .PWM_BITS(4))
    dut2 (.clk(clk), .rst(rst), .i(i2), .force_on(f2), .brightness(b2), .o(o2));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [31:0] e;
    repeat (2) tick;
    exp_q.push_back(32'hF); exp_q.push_back(32'hF); exp_q.push_back(32'hF);
    e = exp_q.pop_front(); tests_run++;
    if (32'(o0) !== e) begin fails++; $display("FAIL reset o0 got %h want %h", o0, e); end
    e = exp_q.pop_front(); tests_run++;
    if (32'(o1) !== e) begin fails++; $display("FAIL reset o1 got %h want %h", o1, e); end
    e = exp_q.pop_front(); tests_run++;
    if (32'(o2) !== e) begin fails++; $display("FAIL reset o2 got %h want %h", o2, e); end
    rst = 1'b0;
  endtask

  // rising-edge instance had i1[1] high through reset: exactly one stretch expected
  task automatic test_high_at_release;
    logic [31:0] e;
    int cnt = 0;
    exp_q.push_back(32'd8);
    for (int n = 0; n < 20; n++) begin
      tick;
      if (o1[1] == 1'b0) cnt++;
    end
    e = exp_q.pop_front(); tests_run++;
    if (32'(cnt) !== e) begin fails++; $display("FAIL high_at_release active=%0d want %0d", cnt, e); end
  endtask

  task automatic test_trigger;
    logic [31:0] e;
    for (int n = 0; n < 16; n++) exp_q.push_back((n >= 3 && n <= 10) ? 32'hE : 32'hF);
    for (int n = 0; n < 16; n++) begin
      if (n == 0) i0[0] = 1'b1;
      tick;
      e = exp_q.pop_front(); tests_run++;
      if (32'(o0) !== e) begin fails++; $display("FAIL trigger n=%0d got %h want %h", n, o0, e); end
    end
  endtask

  task automatic test_retrigger;
    logic [31:0] e;
    for (int n = 0; n < 20; n++) exp_q.push_back((n >= 3 && n <= 15) ? 32'hE : 32'hF);
    for (int n = 0; n < 20; n++) begin
      if (n == 0) i0[0] = 1'b0;
      if (n == 5) i0[0] = 1'b1;
      tick;
      e = exp_q.pop_front(); tests_run++;
      if (32'(o0) !== e) begin fails++; $display("FAIL retrigger n=%0d got %h want %h", n, o0, e); end
    end
  endtask

  task automatic test_force;
    logic [31:0] e;
    for (int n = 0; n < 14; n++) exp_q.push_back((n <= 10) ? 32'hB : 32'hF);
    for (int n = 0; n < 14; n++) begin
      if (n == 0) begin f0[2] = 1'b1; i0[2] = 1'b1; end
      if (n == 5) f0[2] = 1'b0;
      tick;
      e = exp_q.pop_front(); tests_run++;
      if (32'(o0) !== e) begin fails++; $display("FAIL force n=%0d got %h want %h", n, o0, e); end
    end
  endtask

  task automatic test_pwm0;
    logic [31:0] e;
    for (int n = 0; n < 12; n++) exp_q.push_back((n >= 5 && n <= 9) ? 32'hD : 32'hF);
    for (int n = 0; n < 12; n++) begin
      if (n == 0)  begin f0[1] = 1'b1; b0 = 1'b0; end
      if (n == 5)  b0 = 1'b1;
      if (n == 10) f0[1] = 1'b0;
      tick;
      e = exp_q.pop_front(); tests_run++;
      if (32'(o0) !== e) begin fails++; $display("FAIL pwm0 n=%0d got %h want %h", n, o0, e); end
    end
  endtask

  task automatic test_rising_only;
    logic [31:0] e;
    for (int n = 0; n < 15; n++) exp_q.push_back(32'hF);
    for (int n = 0; n < 14; n++) exp_q.push_back((n >= 3 && n <= 10) ? 32'hD : 32'hF);
    for (int n = 0; n < 29; n++) begin
      if (n == 0)  i1[1] = 1'b0;
      if (n == 15) i1[1] = 1'b1;
      tick;
      e = exp_q.pop_front(); tests_run++;
      if (32'(o1) !== e) begin fails++; $display("FAIL rising_only n=%0d got %h want %h", n, o1, e); end
    end
  endtask

  // fall captured at n=20 is seen by the trigger at n=21 (last reload), so active ends at 29
  task automatic test_level;
    logic [31:0] e;
    for (int n = 0; n < 34; n++) exp_q.push_back((n >= 3 && n <= 29) ? 32'hB : 32'hF);
    for (int n = 0; n < 34; n++) begin
      if (n == 0)  i2[2] = 1'b1;
      if (n == 20) i2[2] = 1'b0;
      tick;
      e = exp_q.pop_front(); tests_run++;
      if (32'(o2) !== e) begin fails++; $display("FAIL level n=%0d got %h want %h", n, o2, e); end
    end
  endtask

  task automatic test_pwm;
    logic [4:0]  br [4] = '{5'd4, 5'd16, 5'd31, 5'd0};
    logic [31:0] ex [4] = '{32'd8, 32'd32, 32'd32, 32'd0};
    logic [31:0] e;
    f2[3] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      int cnt = 0;
      b2 = br[k];
      exp_q.push_back(ex[k]);
      tick;
      for (int n = 0; n < 32; n++) begin
        tick;
        if (o2[3] == 1'b0) cnt++;
      end
      e = exp_q.pop_front(); tests_run++;
      if (32'(cnt) !== e) begin fails++; $display("FAIL pwm bright=%0d active=%0d want %0d", br[k], cnt, e); end
    end
    f2[3] = 1'b0;
    b2 = 5'd16;
  endtask

  task automatic test_reset_mid;
    logic [31:0] e;
    for (int n = 0; n < 6; n++) begin
      if (n == 0) i0[0] = 1'b0;
      tick;
    end
    exp_q.push_back(32'hE);
    exp_q.push_back(32'hF);
    for (int n = 0; n < 20; n++) exp_q.push_back(32'hF);
    e = exp_q.pop_front(); tests_run++;
    if (32'(o0) !== e) begin fails++; $display("FAIL reset_mid pre got %h want %h", o0, e); end
    rst = 1'b1;
    i0  = 4'h0;
    #2;
    e = exp_q.pop_front(); tests_run++;
    if (32'(o0) !== e) begin fails++; $display("FAIL reset_mid async got %h want %h", o0, e); end
    repeat (2) tick;
    rst = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick;
      e = exp_q.pop_front(); tests_run++;
      if (32'(o0) !== e) begin fails++; $display("FAIL reset_mid idle n=%0d got %h want %h", n, o0, e); end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i0 = 4'h0; f0 = 4'h0; b0 = 1'b1;
    i1 = 4'b0010; f1 = 4'h0; b1 = 1'b1;
    i2 = 4'h0; f2 = 4'h0; b2 = 5'd16;
    #1;
    test_reset;
    test_high_at_release;
    test_trigger;
    test_retrigger;
    test_force;
    test_pwm0;
    test_rising_only;
    test_level;
    test_pwm;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
